osd_menu_render: RTL and testbench



---
 rtl/osd_menu_render.sv | 227 ++++++++++++++++++++++
 tb/tb_osd_menu_render.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_menu_render.sv
// On-screen menu overlay: fetches text codes and glyph rows from the menu RAM
// and composites an 8x8 character window onto the incoming pixel stream.
module osd_menu_render #(
  parameter int          OSD_X     = 64,
  parameter int          OSD_Y     = 48,
  parameter int          COLS      = 32,
  parameter int          ROWS      = 16,
  parameter logic [10:0] TEXT_BASE = 11'h000,
  parameter logic [10:0] FONT_BASE = 11'h500,
  parameter logic [23:0] FG_RGB    = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_pix,
  input  logic        osd_en,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  output logic [10:0] mem_addr,
  output logic        mem_ce,
  input  logic [7:0]  mem_data,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);

  typedef enum logic [2:0] {IDLE, CADDR, CWAIT, FADDR, FWAIT, HOLD} state_t;

  localparam logic [11:0] TRIG_LO = 12'(OSD_X - 8);
  localparam logic [11:0] TRIG_HI = 12'(OSD_X - 8 + COLS * 8);
  localparam logic [11:0] X_LO    = 12'(OSD_X);
  localparam logic [11:0] X_HI    = 12'(OSD_X + COLS * 8);
  localparam logic [10:0] Y_LO    = 11'(OSD_Y);
  localparam logic [10:0] Y_HI    = 11'(OSD_Y + ROWS * 8);

  state_t      state_q, state_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  ln_q, ln_d;
  logic        de_prev_q, de_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        en_frame_q, en_frame_d;
  logic [10:0] mem_addr_q, mem_addr_d;
  logic        font_ok_q, font_ok_d;
  logic [7:0]  next_glyph_q, next_glyph_d;
  logic [7:0]  shift_q, shift_d;
  logic        out_de_q, out_de_d;
  logic        out_hs_q, out_hs_d;
  logic        out_vs_q, out_vs_d;
  logic [7:0]  out_r_q, out_r_d;
  logic [7:0]  out_g_q, out_g_d;
  logic [7:0]  out_b_q, out_b_d;

  logic        de_fall, vs_rise;
  logic [11:0] px_e, trig_rel;
  logic [10:0] ln_e, ln_rel;
  logic        in_x, in_y, line_ok, win, trig, load, pix_bit, code_ok;
  logic [10:0] text_addr, font_addr;

  // Edges are judged on pixel ticks so a slow ce_pix sees each edge once.
  always_comb begin
    de_fall   = ce_pix & de_prev_q & ~vid_de;
    vs_rise   = ce_pix & vid_vs & ~vs_prev_q;
    de_prev_d = ce_pix ? vid_de : de_prev_q;
    vs_prev_d = ce_pix ? vid_vs : vs_prev_q;

    px_d = px_q;
    if (de_fall)
      px_d = '0;
    else if (ce_pix & vid_de)
      px_d = px_q + 11'd1;

    ln_d = ln_q;
    if (vs_rise)
      ln_d = '0;
    else if (de_fall)
      ln_d = ln_q + 10'd1;

    en_frame_d = vs_rise ? osd_en : en_frame_q;
  end

  always_comb begin
    px_e     = {1'b0, px_q};
    ln_e     = {1'b0, ln_q};
    trig_rel = px_e - TRIG_LO;
    ln_rel   = ln_e - Y_LO;
    in_x     = (px_e >= X_LO) && (px_e < X_HI);
    in_y     = (ln_e >= Y_LO) && (ln_e < Y_HI);
    line_ok  = en_frame_q & vid_de & in_y;
    win      = line_ok & in_x;
    // Trigger and load phases share the low bits since OSD_X-8 and OSD_X agree mod 8.
    trig     = ce_pix & line_ok & (px_e >= TRIG_LO) & (px_e < TRIG_HI)
               & (px_e[2:0] == TRIG_LO[2:0]);
    load     = ce_pix & win & (px_e[2:0] == X_LO[2:0]);
    text_addr = 11'(32'(TEXT_BASE) + (32'(ln_rel) >> 3) * 32'(COLS) + (32'(trig_rel) >> 3));
    font_addr = 11'(32'(FONT_BASE) + ((32'(mem_data) - 32'h20) << 3) + 32'(ln_rel[2:0]));
    code_ok   = (mem_data >= 8'h20) && (mem_data <= 8'h7F);
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    font_ok_d    = font_ok_q;
    next_glyph_d = next_glyph_q;
    case (state_q)
      IDLE, HOLD: begin
        if (trig) begin
          state_d    = CADDR;
          mem_addr_d = text_addr;
        end
      end
      CADDR: state_d = CWAIT;
      CWAIT: begin
        state_d    = FADDR;
        mem_addr_d = font_addr;
        font_ok_d  = code_ok;
      end
      FADDR: state_d = FWAIT;
      FWAIT: begin
        state_d      = HOLD;
        next_glyph_d = font_ok_q ? mem_data : 8'h00;
      end
      default: state_d = IDLE;
    endcase
    if (de_fall) begin
      state_d      = IDLE;
      next_glyph_d = 8'h00;
    end
  end

  assign mem_ce = (state_q == CADDR) | ((state_q == FADDR) & font_ok_q);

  // On a load tick bit 0 is consumed immediately, so the register keeps the rest.
  always_comb begin
    shift_d = shift_q;
    pix_bit = shift_q[0];
    if (ce_pix) begin
      if (load) begin
        pix_bit = next_glyph_q[0];
        shift_d = next_glyph_q >> 1;
      end else begin
        shift_d = shift_q >> 1;
      end
    end
    if (de_fall)
      shift_d = 8'h00;
  end

  always_comb begin
    out_de_d = out_de_q;
    out_hs_d = out_hs_q;
    out_vs_d = out_vs_q;
    out_r_d  = out_r_q;
    out_g_d  = out_g_q;
    out_b_d  = out_b_q;
    if (ce_pix) begin
      out_de_d = vid_de;
      out_hs_d = vid_hs;
      out_vs_d = vid_vs;
      if (win && pix_bit) begin
        out_r_d = FG_RGB[23:16];
        out_g_d = FG_RGB[15:8];
        out_b_d = FG_RGB[7:0];
      end else if (win) begin
        out_r_d = {1'b0, vid_r[7:1]};
        out_g_d = {1'b0, vid_g[7:1]};
        out_b_d = {1'b0, vid_b[7:1]};
      end else begin
        out_r_d = vid_r;
        out_g_d = vid_g;
        out_b_d = vid_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      px_q         <= '0;
      ln_q         <= '0;
      de_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      en_frame_q   <= 1'b0;
      mem_addr_q   <= '0;
      font_ok_q    <= 1'b0;
      next_glyph_q <= '0;
      shift_q      <= '0;
      out_de_q     <= 1'b0;
      out_hs_q     <= 1'b0;
      out_vs_q     <= 1'b0;
      out_r_q      <= '0;
      out_g_q      <= '0;
      out_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      ln_q         <= ln_d;
      de_prev_q    <= de_prev_d;
      vs_prev_q    <= vs_prev_d;
      en_frame_q   <= en_frame_d;
      mem_addr_q   <= mem_addr_d;
      font_ok_q    <= font_ok_d;
      next_glyph_q <= next_glyph_d;
      shift_q      <= shift_d;
      out_de_q     <= out_de_d;
      out_hs_q     <= out_hs_d;
      out_vs_q     <= out_vs_d;
      out_r_q      <= out_r_d;
      out_g_q      <= out_g_d;
      out_b_q      <= out_b_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign out_de   = out_de_q;
  assign out_hs   = out_hs_q;
  assign out_vs   = out_vs_q;
  assign out_r    = out_r_q;
  assign out_g    = out_g_q;
  assign out_b    = out_b_q;

endmodule

// File: tb/tb_osd_menu_render.sv
// Directed bench for osd_menu_render: small 4x2 window at (64,48) over a
// synchronous-read RAM model, checking pixels, fetch addresses and timing.
module tb_osd_menu_render;
  localparam int OSD_X = 64;
  localparam int OSD_Y = 48;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic        osd_en = 1'b0;
  logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic [7:0]  vid_r = '0, vid_g = '0, vid_b = '0;
  logic [10:0] mem_addr;
  logic        mem_ce;
  logic [7:0]  mem_data = '0;
  logic        out_de, out_hs, out_vs;
  logic [7:0]  out_r, out_g, out_b;

  osd_menu_render #(.OSD_X(OSD_X), .OSD_Y(OSD_Y), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .osd_en(osd_en),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_data(mem_data),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:2047];
  logic [10:0] rd_log [$];
  logic [10:0] exp_log [$];
  logic [23:0] cap_rgb [0:127];
  logic        cap_de [0:127];
  logic [7:0]  exp_gl [0:3] = '{8'h0C, 8'h00, 8'h81, 8'h00};
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          slow = 1'b0;

  always @(posedge clk) if (mem_ce) mem_data <= ram[mem_addr];
  always @(negedge clk) if (mem_ce) rd_log.push_back(mem_addr);

  function automatic logic [23:0] in_rgb(input int i);
    logic [7:0] r, b;
    r = 8'(128 + i - 64);
    b = 8'(192 - i);
    return {r, 8'h80, b};
  endfunction

  function automatic logic [23:0] exp_rgb(input int i, input logic ov);
    logic [23:0] rgb;
    logic [7:0]  gl;
    rgb = in_rgb(i);
    if (ov && i >= OSD_X && i < OSD_X + COLS * 8) begin
      gl = exp_gl[(i - OSD_X) / 8];
      if (gl[(i - OSD_X) % 8]) return 24'hFFFF00;
      return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
    end
    return rgb;
  endfunction

  // One pixel tick; in slow mode three idle clocks follow, and outputs are read after them.
  task automatic pix(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
    @(negedge clk);
    vid_de = de; vid_hs = hs; vid_vs = vs;
    {vid_r, vid_g, vid_b} = rgb;
    ce_pix = 1'b1;
    @(posedge clk);
    if (slow) begin
      @(negedge clk);
      ce_pix = 1'b0;
      repeat (3) @(posedge clk);
    end
    #1;
  endtask

  task automatic line(input int nact, input int nblank);
    for (int i = 0; i < nact; i++) begin
      pix(1'b1, 1'b0, 1'b0, in_rgb(i));
      if (i < 128) begin
        cap_rgb[i] = {out_r, out_g, out_b};
        cap_de[i]  = out_de;
      end
    end
    for (int i = 0; i < nblank; i++) pix(1'b0, 1'b1, 1'b0, 24'h0);
  endtask

  // The de-high tick makes the vs rise coincide with a de fall.
  task automatic vsync();
    pix(1'b1, 1'b0, 1'b0, 24'h0);
    pix(1'b0, 1'b0, 1'b1, 24'h0);
    pix(1'b0, 1'b0, 1'b1, 24'h0);
    pix(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic run_to_window();
    vsync();
    for (int l = 0; l < OSD_Y; l++) line(1, 1);
    rd_log.delete();
    line(100, 4);
  endtask

  task automatic check_line(input string nm, input logic ov);
    for (int i = 0; i < 100; i++) begin
      logic [23:0] e;
      e = exp_rgb(i, ov);
      n_cmp++;
      if (cap_rgb[i] !== e || cap_de[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL %s px=%0d got rgb=%06h de=%b want rgb=%06h de=1", nm, i, cap_rgb[i], cap_de[i], e);
      end
    end
  endtask

  task automatic check_log(input string nm);
    n_cmp++;
    if (rd_log.size() != exp_log.size()) begin
      n_bad++;
      $display("FAIL %s read count got=%0d want=%0d", nm, rd_log.size(), exp_log.size());
    end else begin
      for (int i = 0; i < exp_log.size(); i++) begin
        n_cmp++;
        if (rd_log[i] !== exp_log[i]) begin
          n_bad++;
          $display("FAIL %s read[%0d] got=%03h want=%03h", nm, i, rd_log[i], exp_log[i]);
        end
      end
    end
    $display("%s: %0d RAM reads checked", nm, rd_log.size());
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_de, out_hs, out_vs, out_r, out_g, out_b, mem_ce, mem_addr} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%010h want=0", {out_de, out_hs, out_vs, out_r, out_g, out_b, mem_ce, mem_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (3'(dut.state_q) !== 3'd0 || mem_ce !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle state=%0d mem_ce=%b want state=0 mem_ce=0", 3'(dut.state_q), mem_ce);
    end
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    osd_en = 1'b0;
    pix(1'b0, 1'b1, 1'b0, 24'h112233);
    n_cmp++;
    if ({out_de, out_hs, out_vs} !== 3'b010 || {out_r, out_g, out_b} !== 24'h112233) begin
      n_bad++;
      $display("FAIL sync_hs got=%b/%06h want=010/112233", {out_de, out_hs, out_vs}, {out_r, out_g, out_b});
    end
    pix(1'b1, 1'b0, 1'b0, 24'h445566);
    n_cmp++;
    if ({out_de, out_hs, out_vs} !== 3'b100 || {out_r, out_g, out_b} !== 24'h445566) begin
      n_bad++;
      $display("FAIL sync_de got=%b/%06h want=100/445566", {out_de, out_hs, out_vs}, {out_r, out_g, out_b});
    end
    run_to_window();
    check_line("passthrough", 1'b0);
    exp_log.delete();
    check_log("passthrough");
  endtask

  task automatic test_vs_de_collision();
    line(1, 1);
    line(1, 1);
    vsync();
    n_cmp++;
    if (dut.ln_q !== 10'd0) begin
      n_bad++;
      $display("FAIL vs_de_collision ln got=%0d want=0", dut.ln_q);
    end
    $display("test_vs_de_collision done");
  endtask

  task automatic test_glyph_render(input string nm);
    osd_en = 1'b1;
    run_to_window();
    check_line(nm, 1'b1);
    exp_log = '{11'h000, 11'h608, 11'h001, 11'h002, 11'h7F8, 11'h003};
    check_log(nm);
  endtask

  task automatic test_slow_ce();
    slow = 1'b1;
    test_glyph_render("slow_ce");
    slow = 1'b0;
  endtask

  task automatic test_mid_frame_enable();
    osd_en = 1'b0;
    vsync();
    for (int l = 0; l < OSD_Y; l++) begin
      if (l == 20) osd_en = 1'b1;
      line(1, 1);
    end
    rd_log.delete();
    line(100, 4);
    check_line("midframe_off", 1'b0);
    exp_log.delete();
    check_log("midframe_off");
    test_glyph_render("midframe_on");
  endtask

  task automatic test_reset_mid_line();
    bit seen;
    int i;
    osd_en = 1'b1;
    vsync();
    for (int l = 0; l < OSD_Y; l++) line(1, 1);
    seen = 1'b0;
    i = 0;
    while (!seen && i < 100) begin
      pix(1'b1, 1'b0, 1'b0, in_rgb(i));
      seen = mem_ce;
      i++;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL reset_mid_line mem_ce got=0 want=1 within 100 ticks");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_de, out_hs, out_vs, out_r, out_g, out_b, mem_ce, mem_addr} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_mid_line outputs got=%010h want=0", {out_de, out_hs, out_vs, out_r, out_g, out_b, mem_ce, mem_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (3'(dut.state_q) !== 3'd0 || mem_ce !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_line idle state=%0d mem_ce=%b want 0/0", 3'(dut.state_q), mem_ce);
    end
    rd_log.delete();
    for (int k = i; k < 100; k++) pix(1'b1, 1'b0, 1'b0, in_rgb(k));
    pix(1'b0, 1'b1, 1'b0, 24'h0);
    for (int l = 0; l < OSD_Y; l++) line(1, 1);
    line(100, 4);
    check_line("after_reset", 1'b0);
    exp_log.delete();
    check_log("after_reset");
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 8'hA5;
    ram[11'h000] = 8'h41;
    ram[11'h001] = 8'h05;
    ram[11'h002] = 8'h7F;
    ram[11'h003] = 8'h80;
    ram[11'h608] = 8'h0C;
    ram[11'h7F8] = 8'h81;

    test_reset();
    test_passthrough();
    test_vs_de_collision();
    test_glyph_render("glyph_render");
    test_slow_ce();
    test_mid_frame_enable();
    test_reset_mid_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
